// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with registered or first-word-fall-through
// read, almost-full/empty thresholds, occupancy count and sticky error flags.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           data_out,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rv_q, rv_d, ovf_q, ovf_d, unf_q, unf_d;
    logic             we, re;

    // Acceptance uses only registered flags, so wr_en/rd_en never reach a flag combinationally.
    always_comb begin
        we    = wr_en & ~full;
        re    = rd_en & ~empty;
        wp_d  = we ? wp_q + 1'b1 : wp_q;
        rp_d  = re ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + CW'(we) - CW'(re);
        dout_d = re ? mem[rp_q] : dout_q;
        rv_d  = re;
        ovf_d = (wr_en & full) | (ovf_q & ~clr_err);
        unf_d = (rd_en & empty) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            rv_q   <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rv_q   <= rv_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wp_q] <= data_in;
    end

    assign full         = cnt_q == CW'(DEPTH);
    assign empty        = cnt_q == '0;
    assign almost_full  = cnt_q >= CW'(AF_LEVEL);
    assign almost_empty = cnt_q <= CW'(AE_LEVEL);
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign data_out     = (FWFT != 0) ? mem[rp_q] : dout_q;
    assign rd_valid     = (FWFT != 0) ? ~empty : rv_q;
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed scoreboard bench for fifo_param in registered and FWFT read modes.
module tb_fifo_param;
    logic       clk, rst;
    logic [7:0] din, dout0, d1, dout1;
    logic       wr, rd, clr, rv0, full0, empty0, af0, ae0, ovf0, unf0;
    logic [2:0] cnt0, cnt1;
    logic       w1, r1, rv1, full1, empty1, af1, ae1, ovf1, unf1;
    int         tests = 0, fails = 0;
    logic [7:0] m_q[$], exp_q[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_unf;

    fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u0 (
        .clk(clk), .rst(rst), .data_in(din), .wr_en(wr), .rd_en(rd), .clr_err(clr),
        .data_out(dout0), .rd_valid(rv0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0));

    fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u1 (
        .clk(clk), .rst(rst), .data_in(d1), .wr_en(w1), .rd_en(r1), .clr_err(1'b0),
        .data_out(dout1), .rd_valid(rv1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every registered-mode rd_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rv0 === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
            else chk("rd_data", dout0, exp_q.pop_front());
        end
    end

    task automatic check_flags();
        int n = m_q.size();
        chk("count", cnt0, n);
        chk("full", full0, n == 4);
        chk("empty", empty0, n == 0);
        chk("almost_full", af0, n >= 3);
        chk("almost_empty", ae0, n <= 1);
        chk("overflow", ovf0, m_ovf);
        chk("underflow", unf0, m_unf);
        chk("data_out", dout0, m_dout);
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic acc_w, acc_r;
        wr = w; din = d; rd = r; clr = c;
        acc_r = r && m_q.size() > 0;
        acc_w = w && m_q.size() < 4;
        m_ovf = (w && m_q.size() == 4) || (m_ovf && !c);
        m_unf = (r && m_q.size() == 0) || (m_unf && !c);
        @(posedge clk);
        if (acc_r) begin
            m_dout = m_q.pop_front();
            exp_q.push_back(m_dout);
        end
        if (acc_w) m_q.push_back(d);
        #1;
        wr = 0; rd = 0; clr = 0;
        check_flags();
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_dout = 0; m_ovf = 0; m_unf = 0;
    endtask

    initial begin
        logic [1:0] pat [12] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10,
                                 2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
        rst = 1; wr = 0; rd = 0; clr = 0; din = 0; w1 = 0; r1 = 0; d1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_flags();
        chk("rst_rd_valid", rv0, 0);
        // Reset mid-operation
        step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
        step(0, 0, 1, 0);
        chk("pre_rst_count", cnt0, 3);
        chk("pre_rst_dout", dout0, 8'h11);
        @(negedge clk);
        #2 rst = 1;
        #1;
        model_reset();
        chk("async_rst_count", cnt0, 0);
        chk("async_rst_empty", empty0, 1);
        chk("async_rst_rd_valid", rv0, 0);
        chk("async_rst_dout", dout0, 0);
        @(posedge clk);
        #1 rst = 0;
        step(0, 0, 1, 0);
        chk("post_rst_underflow", unf0, 1);
        step(0, 0, 0, 1);
        chk("clr_underflow", unf0, 0);
        // Fill
        step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0);
        chk("af_after2", af0, 0);
        step(1, 8'h33, 0, 0);
        chk("af_after3", af0, 1);
        chk("full_after3", full0, 0);
        step(1, 8'h44, 0, 0);
        chk("full_after4", full0, 1);
        step(1, 8'h55, 0, 0);
        chk("overflow_5th", ovf0, 1);
        chk("count_5th", cnt0, 4);
        // Drain
        repeat (4) step(0, 0, 1, 0);
        chk("drain_empty", empty0, 1);
        step(0, 0, 1, 0);
        chk("drain_underflow", unf0, 1);
        chk("drain_hold44", dout0, 8'h44);
        step(0, 0, 0, 0);
        chk("rd_valid_drop", rv0, 0);
        step(0, 0, 0, 1);
        chk("clr_both", ovf0 | unf0, 0);
        // Simultaneous read/write at count 2, empty and full
        step(1, 8'hA1, 0, 0); step(1, 8'hA2, 0, 0);
        step(1, 8'hA3, 1, 0);
        chk("both_mid_count", cnt0, 2);
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(1, 8'hB1, 1, 0);
        chk("both_empty_count", cnt0, 1);
        chk("both_empty_unf", unf0, 1);
        step(1, 8'hB2, 0, 0); step(1, 8'hB3, 0, 0); step(1, 8'hB4, 0, 0);
        step(1, 8'hB5, 1, 0);
        chk("both_full_count", cnt0, 3);
        chk("both_full_ovf", ovf0, 1);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("clr_after_simul", ovf0 | unf0, 0);
        // Interleaved traffic wrapping the pointers
        for (int i = 0; i < 12; i++) step(pat[i][1], 8'($urandom_range(255)), pat[i][0], 0);
        while (m_q.size() > 0) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("wrap_drained", exp_q.size(), 0);
        // First-word-fall-through instance
        chk("fwft_rst_valid", rv1, 0);
        d1 = 8'hA5; w1 = 1;
        @(posedge clk);
        #1 w1 = 0;
        chk("fwft_dout", dout1, 8'hA5);
        chk("fwft_valid", rv1, 1);
        chk("fwft_count", cnt1, 1);
        r1 = 1;
        @(posedge clk);
        #1 r1 = 0;
        chk("fwft_empty", empty1, 1);
        chk("fwft_valid_low", rv1, 0);
        chk("fwft_unf", unf1, 0);
        @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
